// File: rtl/uart_rx_if.sv
// Parallel-side bundle of the UART receiver: baud divisor, serial line and received-byte outputs.
// Parity ports exist only when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(
   parameter int unsigned DIV_W = 16
);
   logic [DIV_W-1:0] div;
   logic             serial_in;
   logic [7:0]       data_byte;
   logic             rx_dv;
   logic             rx_busy;
   logic             frame_err;
`ifdef UART_RX_PARITY_EN
   logic             parity_odd;
   logic             parity_err;

   modport master (
      output div, serial_in, parity_odd,
      input  data_byte, rx_dv, rx_busy, frame_err, parity_err
   );
   modport slave (
      input  div, serial_in, parity_odd,
      output data_byte, rx_dv, rx_busy, frame_err, parity_err
   );
`else
   modport master (
      output div, serial_in,
      input  data_byte, rx_dv, rx_busy, frame_err
   );
   modport slave (
      input  div, serial_in,
      output data_byte, rx_dv, rx_busy, frame_err
   );
`endif
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with OVERSAMPLE-x oversampling and mid-bit sampling.
// Optional parity (start + 8 data + parity + stop) enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DIV_W      = 16
) (
   input logic     clk,
   input logic     rst,
   uart_rx_if.slave bus
);
   localparam int unsigned OS_W = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

   if (OVERSAMPLE < 8 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
      $error("uart_rx: OVERSAMPLE must be a power of two and at least 8");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;

   state_t           state, state_d;
   logic             sync1, rxs;
   logic [DIV_W-1:0] tick_cnt, tick_cnt_d;
   logic [OS_W-1:0]  os_cnt, os_d;
   logic [2:0]       bit_idx, bit_d;
   logic [7:0]       shift_reg, shift_d;
   logic [7:0]       data_q, data_d;
   logic             dv_q, dv_d;
   logic             fe_q, fe_d;
   logic             busy_q, busy_d;
   logic [DIV_W-1:0] div_last;
   logic             tick;
`ifdef UART_RX_PARITY_EN
   logic             par_q, par_d;
   logic             pe_q, pe_d;
`endif

   // div==0 behaves as 1; >= keeps a shrinking div from running tick_cnt past its wrap
   assign div_last = (bus.div == '0) ? '0 : bus.div - DIV_W'(1);
   assign tick     = (tick_cnt >= div_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1     <= 1'b1;
         rxs       <= 1'b1;
         state     <= S_IDLE;
         tick_cnt  <= '0;
         os_cnt    <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         data_q    <= '0;
         dv_q      <= 1'b0;
         fe_q      <= 1'b0;
         busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q     <= 1'b0;
         pe_q      <= 1'b0;
`endif
      end else begin
         sync1     <= bus.serial_in;
         rxs       <= sync1;
         state     <= state_d;
         tick_cnt  <= tick_cnt_d;
         os_cnt    <= os_d;
         bit_idx   <= bit_d;
         shift_reg <= shift_d;
         data_q    <= data_d;
         dv_q      <= dv_d;
         fe_q      <= fe_d;
         busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
         par_q     <= par_d;
         pe_q      <= pe_d;
`endif
      end
   end

   always_comb begin
      state_d    = state;
      tick_cnt_d = tick ? '0 : tick_cnt + DIV_W'(1);
      os_d       = tick ? os_cnt + OS_W'(1) : os_cnt;
      bit_d      = bit_idx;
      shift_d    = shift_reg;
      data_d     = data_q;
      dv_d       = 1'b0;
      fe_d       = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d      = par_q;
      pe_d       = 1'b0;
`endif
      unique case (state)
         S_IDLE: begin
            // counters held clear so the start bit is timed from its edge
            tick_cnt_d = '0;
            os_d       = '0;
            if (!rxs) state_d = S_START;
         end
         S_START: begin
            if (tick && os_cnt == OS_HALF) begin
               if (rxs) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
                  os_d    = '0;
                  bit_d   = '0;
               end
            end
         end
         S_DATA: begin
            if (tick && os_cnt == OS_LAST) begin
               shift_d = {rxs, shift_reg[7:1]};
               os_d    = '0;
               bit_d   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (tick && os_cnt == OS_LAST) begin
               par_d   = rxs;
               os_d    = '0;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            // leave at mid stop bit so a following start edge is never missed
            if (tick && os_cnt == OS_LAST) begin
               if (!rxs) begin
                  fe_d    = 1'b1;
                  state_d = S_BREAK;
`ifdef UART_RX_PARITY_EN
               end else if ((^shift_reg ^ par_q) != bus.parity_odd) begin
                  pe_d    = 1'b1;
                  state_d = S_IDLE;
`endif
               end else begin
                  data_d  = shift_reg;
                  dv_d    = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_BREAK: begin
            if (rxs) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   assign bus.data_byte = data_q;
   assign bus.rx_dv     = dv_q;
   assign bus.frame_err = fe_q;
   assign bus.rx_busy   = busy_q;
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err = pe_q;
`endif
endmodule
